// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter peripheral
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int CON_IRQ_EN = 0;
  localparam int CON_BUSY = 1;
  localparam int CON_DONE = 2;
  localparam int CON_OVF = 3;
  localparam int CON_EMPTY = 4;
  localparam int CON_FULL = 5;
  localparam logic [31:0] ADDR_TXD_DEF = 32'h4000_0018;
  localparam logic [31:0] ADDR_CON_DEF = 32'h4000_0020;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; a push while full is accepted only alongside a pop
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         reset,
  input  logic         clk,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] n;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = n == (AW+1)'(DEPTH);
  assign empty = n == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      n <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      n <= n + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with FIFO and frame-done interrupt.
// Define UART_TX_IRQ_EN to implement the irq_en register and the irq output.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10417,
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD = ADDR_TXD_DEF,
  parameter logic [31:0] ADDR_CON = ADDR_CON_DEF
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  tx_state_t state, state_n;
  logic wr_txd, wr_con, full, empty, pop, bit_end, frame_end, busy;
  logic done, ovf, irq_en, unused;
  logic [7:0] head, sh;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [31:0] con;
  assign wr_txd = wr && addr == ADDR_TXD;
  assign wr_con = wr && addr == ADDR_CON;
  assign bit_end = cnt == LAST;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) fifo (
    .reset(reset),
    .clk(clk),
    .push(wr_txd),
    .pop(pop),
    .din(wdata[7:0]),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = empty ? IDLE : START;
      START: state_n = bit_end ? DATA : START;
      DATA: state_n = bit_end && idx == 3'd7 ? STOP : DATA;
      STOP: state_n = !bit_end ? STOP : empty ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    frame_end = state == STOP && bit_end;
    pop = !empty && (state == IDLE || frame_end);
    tx = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cnt <= !busy || bit_end ? '0 : cnt + 16'd1;
      idx <= state != DATA ? '0 : bit_end ? idx + 3'd1 : idx;
      sh <= pop ? head : state == DATA && bit_end ? sh >> 1 : sh;
      done <= frame_end | (done & ~(wr_con & wdata[2]));
      ovf <= (wr_txd & full & ~pop) | (ovf & ~(wr_con & wdata[3]));
    end
`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq_en <= 1'b0;
    else if (wr_con) irq_en <= wdata[0];
  assign irq = irq_en & done;
  assign unused = ^{wdata[31:8], wdata[7:4], wdata[1]};
`else
  assign irq_en = 1'b0;
  assign irq = 1'b0;
  assign unused = ^{wdata[31:8], wdata[7:4], wdata[1:0]};
`endif
  always_comb begin
    con = '0;
    con[CON_IRQ_EN] = irq_en;
    con[CON_BUSY] = busy;
    con[CON_DONE] = done;
    con[CON_OVF] = ovf;
    con[CON_EMPTY] = empty;
    con[CON_FULL] = full;
    rdata = rd && addr == ADDR_CON ? con : '0;
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed stimulus checked against a frame-level model every cycle plus literal pins.
module tb_uart_tx_port;
  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] CON = 32'h4000_0020;
  logic reset = 1'b0, clk = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic tx, irq;
  int checks = 0, errors = 0;

  uart_tx_port #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .reset(reset), .clk(clk), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // frame-level model: a queue of pending bytes and a position within the current 40-clock frame
  logic [7:0] q[$];
  logic [7:0] cur = '0;
  bit busy_m = 0, done_m = 0, ovf_m = 0, irq_en_m = 0;
  int tf = 0;
  always @(posedge clk or negedge reset) begin
    int pre;
    bit endf, dop;
    if (!reset) begin
      q.delete();
      busy_m = 0; done_m = 0; ovf_m = 0; irq_en_m = 0; tf = 0;
    end else begin
      pre = q.size();
      endf = busy_m && tf == 39;
      dop = pre > 0 && (!busy_m || endf);
      if (wr && addr == CON) begin
        if (wdata[2]) done_m = 0;
        if (wdata[3]) ovf_m = 0;
`ifdef UART_TX_IRQ_EN
        irq_en_m = wdata[0];
`endif
      end
      if (endf) done_m = 1;
      if (dop) begin
        cur = q.pop_front();
        busy_m = 1;
        tf = 0;
      end else if (endf) busy_m = 0;
      else if (busy_m) tf++;
      if (wr && addr == TXD) begin
        if (pre < 4 || dop) q.push_back(wdata[7:0]);
        else ovf_m = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic etx;
    logic [31:0] econ;
    etx = !busy_m ? 1'b1 : tf < 4 ? 1'b0 : tf >= 36 ? 1'b1 : cur[tf/4-1];
    econ = {26'b0, q.size() == 4, q.size() == 0, ovf_m, done_m, busy_m, irq_en_m};
    chk("model_tx", {31'b0, tx}, {31'b0, etx});
    chk("model_irq", {31'b0, irq}, {31'b0, irq_en_m & done_m});
    chk("model_rdata", rdata, rd && addr == CON ? econ : 32'h0);
  end

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic read_con(input string name, input logic [31:0] want);
    rd = 1'b1; addr = CON;
    #1 chk(name, rdata, want);
    rd = 1'b0; addr = '0;
  endtask

  logic [9:0] frame;
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("reset_tx", {31'b0, tx}, 32'h1);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    read_con("reset_con", 32'h10);
    addr = TXD;
    #1 chk("txd_read", rdata, 32'h0);
    addr = '0;
    @(posedge clk); #1;
    // single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
    frame = 10'b1101001010;
    write(TXD, 32'hA5);
    chk("a5_pre_start", {31'b0, tx}, 32'h1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("a5_bit", {31'b0, tx}, {31'b0, frame[k/4]});
    end
    read_con("a5_busy_con", 32'h12);
    @(posedge clk); #1;
    read_con("a5_done_con", 32'h14);
    // burst of five then three more while full
    write(CON, 32'h0C);
    for (int i = 1; i <= 8; i++) write(TXD, i);
    read_con("burst_full_con", 32'h2A);
    repeat (193) @(posedge clk);
    #1 read_con("burst_last_stop_con", 32'h1E);
    @(posedge clk); #1;
    read_con("burst_end_con", 32'h1C);
    // interrupt on frame completion
    write(CON, 32'h0C);
    write(CON, 32'h01);
    write(TXD, 32'h55);
    repeat (40) @(posedge clk);
    #1 chk("irq_before_end", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
`ifdef UART_TX_IRQ_EN
    chk("irq_rise", {31'b0, irq}, 32'h1);
    read_con("irq_con", 32'h15);
`else
    chk("irq_tied", {31'b0, irq}, 32'h0);
    read_con("irq_con", 32'h14);
`endif
    write(CON, 32'h05);
    chk("irq_fall", {31'b0, irq}, 32'h0);
`ifdef UART_TX_IRQ_EN
    read_con("irq_en_kept", 32'h11);
`else
    read_con("irq_en_kept", 32'h10);
`endif
    // reset mid-DATA with two bytes queued
    write(TXD, 32'h11);
    write(TXD, 32'h22);
    write(TXD, 32'h33);
    repeat (8) @(posedge clk);
    #1 chk("mid_data_tx", {31'b0, tx}, 32'h0);
    #1 reset = 1'b0;
    #1 chk("async_reset_tx", {31'b0, tx}, 32'h1);
    read_con("in_reset_con", 32'h10);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {31'b0, tx}, 32'h1);
    end
    read_con("post_reset_con", 32'h10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter peripheral, responder on the CPU data bus (`rd`/`wr`/`addr`/`wdata` -> `rdata`). The CPU writes bytes to a data register; the block buffers them in a small FIFO and serialises them onto `tx` as 8N1 frames. It reports status through a control register and raises a level interrupt on frame completion. It sits beside the data memory in the peripheral address space (address bit 30 set) and drives the board `UART_TX` pin.

## Interface
- `BAUD_DIV`, 10417: clocks per bit (100 MHz / 9600). Legal range is 2..65535.
- `FIFO_DEPTH`, 4: transmit FIFO entries. Must be a power of two, at least 2.
- `ADDR_TXD`, 32'h4000_0018: data register address.
- `ADDR_CON`, 32'h4000_0020: control/status register address.
- `reset`  in  1: reset, asynchronous, active-low.
- `clk`  in  1: clock clk.
- `rd`  in  1: bus read strobe.
- `wr`  in  1: bus write strobe.
- `addr`  in  32: bus byte address, full compare.
- `wdata`  in  32: bus write data.
- `rdata`  out  32: read data. Combinational; 0 unless `rd` is high and the address matches.
- `tx`  out  1: serial line; idles at 1.
- `irq`  out  1: level interrupt request.

## Operation
- Write to TXD: `wdata[7:0]` is enqueued. If the FIFO is full, the byte is dropped and sticky `ovf` is set.
- Write to CON:
  - `wdata[0]` loads `irq_en`.
  - `wdata[2]`=1 clears `done`.
  - `wdata[3]`=1 clears `ovf`.
  - Other bits are ignored.
- Read CON returns {26'b0, full, empty, ovf, done, busy, irq_en}, bits 5..0.
- Read TXD returns 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty. The head is popped into the shift register.
  - START -> DATA after BAUD_DIV clocks.
  - DATA sends 8 bits LSB first, each BAUD_DIV clocks, then -> STOP.
  - STOP holds `tx`=1 for BAUD_DIV clocks. `done` is then set. If the FIFO is non-empty, the next state is START with a pop on the same edge. Otherwise the next state is IDLE.
- `busy` = state != IDLE.
- `irq` = `irq_en` & `done`.
- Bit counter: 0..BAUD_DIV-1, wraps at each bit boundary.
- Bit index: 0..7.

## Timing
- Reset values: `tx`=1, `irq`=0, FIFO empty, `irq_en`=0, `done`=0, `ovf`=0, state IDLE. `rdata` is 0 while `rd` is low.
- Reset mid-frame aborts immediately. `tx` returns to 1 asynchronously and the FIFO is flushed.
- Write latency: a TXD write sampled at edge N makes the FIFO non-empty after N. At edge N+1, state is START and `tx`=0, so first start bit edge = write edge + 1 clock.
- Frame length: exactly 10*BAUD_DIV clocks.
- Back-to-back frames have zero idle gap.
- Simultaneous TXD write and pop while the FIFO is full: the write is accepted and `ovf` is not set.
- Simultaneous `done` set and CON clear: the set wins.
- Reads have no side effects.

## Configuration
- `UART_TX_IRQ_EN` defined: `irq_en` register and `irq` output are as described.
- `UART_TX_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - `irq_en` is not implemented; CON bit 0 reads 0 and writes to it are ignored.
  - `done` still functions for polling.

## Structure
- Package `uart_pkg` holds:
  - the state enum `tx_state_t`;
  - CON bit index constants (`CON_IRQ_EN`..`CON_FULL`);
  - default address constants.
- Sub-module `uart_tx_fifo` is a synchronous FIFO with push/pop/full/empty and simultaneous push+pop.
- Baud counter and FSM stay in `uart_tx_port`.

## Test plan
- All tests use BAUD_DIV=4.
- Reset: `tx`=1, `irq`=0. Read CON = 0x10 (empty only).
- Single byte: write TXD=0xA5. `tx` low one clock after the write, held 4 clocks. Data bits 1,0,1,0,0,1,0,1 each 4 clocks, then stop 1. `done`=1 at 40 clocks after the start edge. CON reads 0x14.
- Burst of 5 bytes 0x01..0x05 with FIFO_DEPTH=4 and no waits: first byte popped at edge 1, so none is dropped and `ovf`=0. Five contiguous frames, 200 clocks, no idle gap. A sixth to eighth write during frame 1 with the FIFO full sets `ovf`; CON bit 3 = 1.
- IRQ: write CON=0x1, send 0x55. `irq` rises at the end of stop. Write CON=0x5: `irq` falls the next cycle and `irq_en` stays 1.
- Reset asserted mid-DATA with 2 bytes queued: `tx`=1 immediately. After release, CON=0x10 and no further frames are sent.
